// File: rtl/scpad_types_pkg.sv
// Shared scratchpad geometry plus the tile sequencer's state and request types.
// The tile request struct matches the field set latched on acceptance.
package scpad_types_pkg;

   localparam int NUM_COLS        = 32;
   localparam int MAX_DIM_WIDTH   = 5;
   localparam int ROW_IDX_WIDTH   = 5;
   localparam int SPAD_ADDR_WIDTH = 10;
   localparam int TAG_WIDTH       = 4;

   localparam logic [MAX_DIM_WIDTH:0] MAX_DIM = (MAX_DIM_WIDTH+1)'(NUM_COLS);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DONE
   } tile_seq_state_t;

   typedef struct packed {
      logic                       row_or_col;
      logic [SPAD_ADDR_WIDTH-1:0] spad_addr;
      logic [MAX_DIM_WIDTH:0]     num_rows;
      logic [MAX_DIM_WIDTH:0]     num_cols;
      logic [TAG_WIDTH-1:0]       tag;
   } tile_req_t;

   function automatic logic dim_legal(input logic [MAX_DIM_WIDTH:0] dim);
      return (dim != '0) && (dim <= MAX_DIM);
   endfunction

   // One beat per row in row-major mode, one per column otherwise.
   function automatic logic [MAX_DIM_WIDTH:0] beat_count(input tile_req_t req);
      return req.row_or_col ? req.num_rows : req.num_cols;
   endfunction

endpackage

// File: rtl/scpad_tile_seq.sv
// Tile sequencer: expands one tile request into per-row or per-column beats
// for the address mapper, then reports completion, abort or error.
//
//   state | meaning
//   IDLE  | waiting for a tile request, req_ready high
//   ISSUE | presenting beats, index advances on each handshake
//   DONE  | one-cycle done pulse with tag/err/aborted, then back to IDLE
module scpad_tile_seq
   import scpad_types_pkg::*;
(
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_row_or_col,
   input  logic [SPAD_ADDR_WIDTH-1:0] req_spad_addr,
   input  logic [MAX_DIM_WIDTH:0]     req_num_rows,
   input  logic [MAX_DIM_WIDTH:0]     req_num_cols,
   input  logic [TAG_WIDTH-1:0]       req_tag,
   input  logic                       abort,
   output logic                       beat_valid,
   input  logic                       beat_ready,
   output logic                       beat_row_or_col,
   output logic [SPAD_ADDR_WIDTH-1:0] beat_spad_addr,
   output logic [MAX_DIM_WIDTH:0]     beat_num_rows,
   output logic [MAX_DIM_WIDTH:0]     beat_num_cols,
   output logic [MAX_DIM_WIDTH-1:0]   beat_row_id,
   output logic [MAX_DIM_WIDTH-1:0]   beat_col_id,
   output logic                       beat_last,
   output logic [TAG_WIDTH-1:0]       beat_tag,
   output logic                       done_valid,
   output logic [TAG_WIDTH-1:0]       done_tag,
   output logic                       done_err,
   output logic                       done_aborted,
   output logic                       busy
);

   tile_seq_state_t        state_q, state_d;
   logic [MAX_DIM_WIDTH:0] idx_q, idx_d;
   tile_req_t              req_q, req_d;
   logic                   err_q, err_d;
   logic                   aborted_q, aborted_d;

   tile_req_t              req_in;
   logic [MAX_DIM_WIDTH:0] last_idx;
   logic                   is_last;

   assign req_in = '{row_or_col: req_row_or_col,
                     spad_addr:  req_spad_addr,
                     num_rows:   req_num_rows,
                     num_cols:   req_num_cols,
                     tag:        req_tag};

   assign last_idx = beat_count(req_q) - (MAX_DIM_WIDTH+1)'(1);
   assign is_last  = (idx_q == last_idx);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         req_q     <= '0;
         err_q     <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         req_q     <= req_d;
         err_q     <= err_d;
         aborted_q <= aborted_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      req_d           = req_q;
      err_d           = err_q;
      aborted_d       = aborted_q;
      req_ready       = 1'b0;
      beat_valid      = 1'b0;
      beat_row_or_col = 1'b0;
      beat_spad_addr  = '0;
      beat_num_rows   = '0;
      beat_num_cols   = '0;
      beat_row_id     = '0;
      beat_col_id     = '0;
      beat_last       = 1'b0;
      beat_tag        = '0;
      done_valid      = 1'b0;
      done_tag        = '0;
      done_err        = 1'b0;
      done_aborted    = 1'b0;
      busy            = (state_q != IDLE);

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            err_d     = 1'b0;
            aborted_d = 1'b0;
            if (req_valid) begin
               req_d = req_in;
               idx_d = '0;
               if (dim_legal(req_num_rows) && dim_legal(req_num_cols)) begin
                  state_d = ISSUE;
               end else begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end

         ISSUE: begin
            beat_valid      = 1'b1;
            beat_row_or_col = req_q.row_or_col;
            beat_spad_addr  = req_q.spad_addr;
            beat_num_rows   = req_q.num_rows;
            beat_num_cols   = req_q.num_cols;
            beat_tag        = req_q.tag;
            beat_last       = is_last;
            if (req_q.row_or_col) begin
               beat_row_id = idx_q[MAX_DIM_WIDTH-1:0];
            end else begin
               beat_col_id = idx_q[MAX_DIM_WIDTH-1:0];
            end
            // A last-beat handshake takes priority over a coincident abort.
            if (beat_ready && is_last) begin
               idx_d   = idx_q + (MAX_DIM_WIDTH+1)'(1);
               state_d = DONE;
            end else if (abort) begin
               aborted_d = 1'b1;
               state_d   = DONE;
            end else if (beat_ready) begin
               idx_d = idx_q + (MAX_DIM_WIDTH+1)'(1);
            end
         end

         DONE: begin
            done_valid   = 1'b1;
            done_tag     = req_q.tag;
            done_err     = err_q;
            done_aborted = aborted_q;
            idx_d        = '0;
            state_d      = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
